// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decode controller.
//
// Holds the fetch PC, issues word requests to instruction memory over a
// valid/ready handshake and buffers returning words, in order, in a prefetch
// FIFO of DEPTH entries. The FIFO head goes to decode with its PC. A redirect
// flushes the FIFO and arranges for responses that are still in flight to be
// discarded.
//
// Optional feature: define FETCH_BYPASS_EN to let a response reach decode in
// the cycle it arrives when the FIFO is empty. Without it, decode sees only
// registered FIFO state.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request this cycle
//   imem_addr       fetch address (word aligned)
//   imem_rsp_valid  response word valid (in request order, latency >= 1)
//   imem_rsp_data   response instruction word
//   redirect        taken branch/jump from execute
//   redirect_pc     new fetch PC (bits [1:0] ignored)
//   stall           decode cannot accept; hold output
//   instruction     word to decode (NOP when inst_valid = 0)
//   inst_pc         PC of instruction (0 when inst_valid = 0)
//   inst_valid      instruction/inst_pc valid
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        inst_valid
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_word_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    // Request PCs of live (not-to-be-dropped) outstanding fetches.
    logic [31:0]   aq_pc_q [DEPTH];
    logic [PW-1:0] aq_head_q, aq_head_d, aq_tail_q, aq_tail_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW:0] inflight;
    logic        accept, rsp_take, rsp_live, fifo_valid, bypass, push, pop;
    logic        unused_rpc;

    assign unused_rpc = ^redirect_pc[1:0];

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits come from registered state only; a same-cycle pop frees nothing.
    assign inflight       = (CW+1)'(count_q) + (CW+1)'(outstanding_q);
    assign imem_req_valid = !reset && !redirect && (inflight < (CW+1)'(DEPTH));
    assign imem_addr      = reset ? RESET_PC : pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are protocol violations; ignore them.
    assign rsp_take   = !reset && imem_rsp_valid && (outstanding_q != '0);
    assign rsp_live   = rsp_take && (drop_q == '0);
    assign fifo_valid = (count_q != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = !fifo_valid && rsp_live && !redirect;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        inst_valid  = 1'b0;
        instruction = NOP;
        inst_pc     = 32'h0;
        if (!reset && fifo_valid) begin
            inst_valid  = 1'b1;
            instruction = fifo_word_q[head_q];
            inst_pc     = fifo_pc_q[head_q];
        end else if (!reset && bypass) begin
            inst_valid  = 1'b1;
            instruction = imem_rsp_data;
            inst_pc     = aq_pc_q[aq_head_q];
        end
    end

    assign pop  = !reset && fifo_valid && !stall;
    // A bypassed word that decode takes immediately never enters the FIFO.
    assign push = rsp_live && !redirect && !(bypass && !stall);

    always_comb begin
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_take);
        pc_d          = accept ? pc_q + 32'd4 : pc_q;
        head_d        = pop ? inc(head_q) : head_q;
        tail_d        = push ? inc(tail_q) : tail_q;
        count_d       = count_q + CW'(push) - CW'(pop);
        aq_head_d     = (rsp_live && !redirect) ? inc(aq_head_q) : aq_head_q;
        aq_tail_d     = accept ? inc(aq_tail_q) : aq_tail_q;
        drop_d        = (rsp_take && drop_q != '0) ? drop_q - CW'(1) : drop_q;
        if (redirect) begin
            // Everything still in flight, minus a response landing now, gets dropped.
            pc_d      = {redirect_pc[31:2], 2'b00};
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            aq_head_d = '0;
            aq_tail_d = '0;
            drop_d    = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            aq_head_q     <= '0;
            aq_tail_q     <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            aq_head_q     <= aq_head_d;
            aq_tail_q     <= aq_tail_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Storage arrays need no reset; validity is carried by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[tail_q]   <= aq_pc_q[aq_head_q];
            fifo_word_q[tail_q] <= imem_rsp_data;
        end
        if (accept) begin
            aq_pc_q[aq_tail_q] <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_valid;

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .instruction   (instruction),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid)
    );

    always #5 clk = ~clk;

    // Memory side: accepted requests waiting for their response.
    typedef struct {
        logic [31:0] a;
        int          ep;
        int          due;
    } req_t;
    req_t memq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: the stream decode must see is base, base+4, ... of the
    // current epoch; fcount is how many current-epoch words are buffered.
    int          epoch     = 0;
    int          consumed  = 0;
    int          fcount    = 0;
    logic [31:0] base      = RESET_PC;
    logic [31:0] fetch_pc  = RESET_PC;
    int          extra_lat = 0;
    int          rsp_pct   = 100;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check outputs, advance the model.
    task automatic step(input logic rst, input logic rd, input logic [31:0] rdpc,
                        input logic st, input logic rdy);
        logic        rsp, rsp_cur, exp_valid, acc;
        logic [31:0] exp_pc;
        @(negedge clk);
        cyc++;
        reset          = rst;
        redirect       = rd;
        redirect_pc    = rdpc;
        stall          = st;
        imem_req_ready = rdy;
        if (rst) memq.delete();
        rsp = 1'b0;
        if (memq.size() > 0)
            rsp = (memq[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memf(memq[0].a) : $urandom;
        #1;
        if (rst) begin
            chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
            chk("rst_addr", imem_addr, RESET_PC);
            chk("rst_inst_valid", 32'(inst_valid), 32'h0);
            chk("rst_instruction", instruction, NOP);
            chk("rst_inst_pc", inst_pc, 32'h0);
            epoch++;
            fcount   = 0;
            consumed = 0;
            base     = RESET_PC;
            fetch_pc = RESET_PC;
            return;
        end
        rsp_cur   = rsp && (memq[0].ep == epoch);
        exp_valid = (fcount > 0);
`ifdef FETCH_BYPASS_EN
        if (fcount == 0 && rsp_cur && !rd) exp_valid = 1'b1;
`endif
        exp_pc = base + 32'(4 * consumed);
        chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("instruction", instruction, memf(exp_pc));
        end else begin
            chk("idle_inst_pc", inst_pc, 32'h0);
            chk("idle_nop", instruction, NOP);
        end
        chk("req_valid", 32'(imem_req_valid),
            32'(!rd && (fcount + memq.size() < int'(DEPTH))));
        if (imem_req_valid) chk("imem_addr", imem_addr, fetch_pc);
        chk("rsp_into_full_fifo", 32'(rsp_cur && fcount >= int'(DEPTH)), 32'h0);

        acc = imem_req_valid && rdy;
        if (rsp) void'(memq.pop_front());
        if (acc) begin
            memq.push_back('{a: imem_addr, ep: epoch, due: cyc + 1 + extra_lat});
            fetch_pc += 32'd4;
        end
        if (rd) begin
            epoch++;
            base     = {rdpc[31:2], 2'b00};
            fetch_pc = base;
            consumed = 0;
            fcount   = 0;
        end else begin
            if (rsp_cur) fcount++;
            if (exp_valid && !st) begin
                consumed++;
                fcount--;
            end
        end
    endtask

    initial begin
        logic [31:0] tgt;
        reset          = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // Reset, then a plain stream with a latency-1 memory.
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (14) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Decode stalls for 5 cycles, then releases.
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Slow memory so both credits are outstanding, then redirect to 0x100.
        extra_lat = 3;
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("two_outstanding", 32'(memq.size()), 32'd2);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
        extra_lat = 0;
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Unaligned redirect target is forced to a word boundary.
        step(1'b0, 1'b1, 32'h0000_0203, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("redirect_aligned_addr", imem_addr, 32'h0000_0200);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Redirect together with stall and a response in flight.
        step(1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Fetch PC wrap-around.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("wrap_first_addr", imem_addr, 32'hFFFF_FFFC);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Randomized traffic, with a reset in the middle.
        rsp_pct = 60;
        for (int i = 0; i < 700; i++) begin
            if (i % 50 == 0) extra_lat = int'($urandom_range(3));
            if (i == 350) begin
                repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            end
            case ($urandom_range(3))
                0:       tgt = 32'h0000_0100;
                1:       tgt = 32'hFFFF_FFF8 | 32'($urandom_range(7));
                default: tgt = $urandom;
            endcase
            step(1'b0, ($urandom_range(99) < 5), tgt, ($urandom_range(99) < 30),
                 ($urandom_range(99) < 70));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
